mcu_spi: RTL and testbench

SPI slave front end between the IO MCU and the core's MCU-facing blocks (hid, osd, sd card, system). It runs in the core clock domain and oversamples the MCU's SPI mode-0 lines. It deserialises bytes, demultiplexes each transfer to one target, and produces the byte-wide strobe/start/data triple those targets consume. Reply bytes from the selected target are shifted back out on MISO.

---
 rtl/mcu_pkg.sv | 20 ++
 rtl/mcu_spi_if.sv | 25 ++
 rtl/spi_sync_edge.sv | 29 ++
 rtl/mcu_spi.sv | 156 +++++++++++++++
 tb/tb_mcu_spi.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the MCU SPI front end and its targets.
package mcu_pkg;

   typedef enum logic [1:0] {IDLE, TARGET, COMMAND, DATA} state_t;

   typedef logic [1:0] tgt_t;

   localparam tgt_t TGT_SYS = 2'd0;
   localparam tgt_t TGT_HID = 2'd1;
   localparam tgt_t TGT_OSD = 2'd2;
   localparam tgt_t TGT_SDC = 2'd3;

   localparam logic [7:0] IDLE_BYTE_DEF = 8'h5c;

   // Target-select bytes of 4 and above address nothing.
   function automatic logic tgt_valid(input logic [7:0] sel);
      return sel[7:2] == 6'd0;
   endfunction

endpackage

// File: rtl/mcu_spi_if.sv
// Byte-wide strobe/start/data bus between the SPI front end and its targets.
interface mcu_spi_if;
   logic       mcu_start;
   logic       mcu_sys_strobe;
   logic       mcu_hid_strobe;
   logic       mcu_osd_strobe;
   logic       mcu_sdc_strobe;
   logic [7:0] mcu_dout;
   logic [7:0] mcu_sys_din;
   logic [7:0] mcu_hid_din;
   logic [7:0] mcu_osd_din;
   logic [7:0] mcu_sdc_din;

   modport master (
      output mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
      output mcu_dout,
      input  mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din
   );

   modport slave (
      input  mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
      input  mcu_dout,
      output mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous line plus single-cycle edge pulses.
module spi_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta  <= 1'b0;
         level <= 1'b0;
         prev  <= 1'b0;
      end else begin
         meta  <= din;
         level <= meta;
         prev  <= level;
      end
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 slave front end: oversamples the MCU SPI lines in the core clock
// domain and fans received bytes out to the sys/hid/osd/sd-card targets.
module mcu_spi
   import mcu_pkg::*;
#(
   parameter int unsigned CLK_DIV_MIN = 8,
   parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEF
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      spi_io_ss,
   input  logic      spi_io_clk,
   input  logic      spi_io_din,
   output logic      spi_io_dout,
   mcu_spi_if.master bus
);

   logic       sck_lvl, sck_rise, sck_fall;
   logic       ss_lvl, ss_rise, ss_fall;
   logic       mosi_meta, mosi;
   state_t     state, state_next;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic [7:0] rx_byte;
   logic       byte_end;
   tgt_t       tgt;
   logic       tgt_ok;
   logic       done_q, done_q2;
   logic [7:0] din_sel;
   logic [7:0] reply;
   logic [7:0] tx;
   logic [7:0] edge_gap;

   // ss resets low so a transfer interrupted by reset is not resumed until ss
   // is seen high and then low again.
   spi_sync_edge u_sck (.clk(clk), .reset(reset), .din(spi_io_clk),
                        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
   spi_sync_edge u_ss  (.clk(clk), .reset(reset), .din(spi_io_ss),
                        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));

   always_ff @(posedge clk) begin
      if (reset) begin
         mosi_meta <= 1'b0;
         mosi      <= 1'b0;
      end else begin
         mosi_meta <= spi_io_din;
         mosi      <= mosi_meta;
      end
   end

   assign rx_byte  = {shift, mosi};
   assign byte_end = sck_rise && (bit_cnt == 3'd7) && !ss_lvl && (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (ss_lvl) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (ss_fall)  state_next = TARGET;
            TARGET:  if (byte_end) state_next = COMMAND;
            COMMAND: if (byte_end) state_next = DATA;
            default: state_next = state;
         endcase
      end
   end

   always_comb begin
      case (tgt)
         TGT_SYS: din_sel = bus.mcu_sys_din;
         TGT_HID: din_sel = bus.mcu_hid_din;
         TGT_OSD: din_sel = bus.mcu_osd_din;
         default: din_sel = bus.mcu_sdc_din;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt            <= '0;
         shift              <= '0;
         tgt                <= TGT_SYS;
         tgt_ok             <= 1'b0;
         done_q             <= 1'b0;
         done_q2            <= 1'b0;
         reply              <= '0;
         tx                 <= '0;
         bus.mcu_start      <= 1'b0;
         bus.mcu_sys_strobe <= 1'b0;
         bus.mcu_hid_strobe <= 1'b0;
         bus.mcu_osd_strobe <= 1'b0;
         bus.mcu_sdc_strobe <= 1'b0;
         bus.mcu_dout       <= '0;
      end else begin
         bus.mcu_start      <= 1'b0;
         bus.mcu_sys_strobe <= 1'b0;
         bus.mcu_hid_strobe <= 1'b0;
         bus.mcu_osd_strobe <= 1'b0;
         bus.mcu_sdc_strobe <= 1'b0;
         done_q             <= byte_end;
         done_q2            <= done_q;

         if (ss_lvl || state == IDLE) begin
            bit_cnt <= '0;
         end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= rx_byte[6:0];
         end

         if (byte_end) begin
            if (state == TARGET) begin
               tgt    <= rx_byte[1:0];
               tgt_ok <= tgt_valid(rx_byte);
            end else if (tgt_ok) begin
               bus.mcu_dout  <= rx_byte;
               bus.mcu_start <= (state == COMMAND);
               case (tgt)
                  TGT_SYS: bus.mcu_sys_strobe <= 1'b1;
                  TGT_HID: bus.mcu_hid_strobe <= 1'b1;
                  TGT_OSD: bus.mcu_osd_strobe <= 1'b1;
                  default: bus.mcu_sdc_strobe <= 1'b1;
               endcase
            end
         end

         // Sampled two clocks after the strobe so the target has a cycle to update din.
         if (done_q2) reply <= tgt_ok ? din_sel : 8'h00;

         if (ss_lvl)
            tx <= '0;
         else if (state == IDLE && ss_fall)
            tx <= IDLE_BYTE;
         else if (state != IDLE && sck_fall)
            tx <= (bit_cnt == 3'd0) ? reply : {tx[6:0], 1'b0};
      end
   end

   assign spi_io_dout = (state != IDLE) && tx[7];

   always_ff @(posedge clk) begin
      if (reset || ss_rise)         edge_gap <= '1;
      else if (sck_rise || sck_fall) edge_gap <= '0;
      else if (edge_gap != '1)       edge_gap <= edge_gap + 8'd1;
   end

   a_sck_ratio: assert property (@(posedge clk) disable iff (reset)
      (sck_rise || sck_fall) |-> edge_gap >= 8'(CLK_DIV_MIN / 2 - 1));

   a_sck_idle: assert property (@(posedge clk) disable iff (reset)
      ss_lvl |-> !sck_lvl);

endmodule

// File: tb/tb_mcu_spi.sv
// Directed bench for mcu_spi: table of whole transfers plus hand-written corner sequences.
module tb_mcu_spi;

   logic clk = 1'b0;
   logic reset;
   logic ss;
   logic sck;
   logic mosi;
   logic miso;

   mcu_spi_if bus ();

   mcu_spi #(.CLK_DIV_MIN(8), .IDLE_BYTE(8'h5c)) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_io_ss   (ss),
      .spi_io_clk  (sck),
      .spi_io_din  (mosi),
      .spi_io_dout (miso),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0] mask;   // {sdc, osd, hid, sys}
      logic       start;
      logic [7:0] dout;
   } ev_t;

   ev_t ev_q[$];

   always @(negedge clk) begin
      if (bus.mcu_sys_strobe || bus.mcu_hid_strobe || bus.mcu_osd_strobe || bus.mcu_sdc_strobe)
         ev_q.push_back('{mask:  {bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
                                  bus.mcu_hid_strobe, bus.mcu_sys_strobe},
                          start: bus.mcu_start,
                          dout:  bus.mcu_dout});
   end

   typedef struct {
      string       name;
      int unsigned n;
      logic [7:0]  tx   [4];
      logic [3:0]  mask;
      logic [7:0]  miso [4];
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int idx, input string name, input int unsigned n,
                          input logic [7:0] b0, b1, b2, b3, input logic [3:0] mask,
                          input logic [7:0] m0, m1, m2, m3);
      vecs[idx].name = name;
      vecs[idx].n    = n;
      vecs[idx].tx   = '{b0, b1, b2, b3};
      vecs[idx].mask = mask;
      vecs[idx].miso = '{m0, m1, m2, m3};
   endtask

   // clk = 16x sck: 8 clk low, then 8 clk high per bit; MISO read just before the rising edge.
   task automatic spi_bits(input logic [7:0] val, input int unsigned nbits, output logic [7:0] rx);
      rx = '0;
      for (int unsigned i = 0; i < nbits; i++) begin
         mosi = val[3'(7 - i)];
         repeat (8) @(negedge clk);
         rx = {rx[6:0], miso};
         sck = 1'b1;
         repeat (8) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic ss_end(input int unsigned gap);
      repeat (2) @(negedge clk);
      ss = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_ev(input string name, input int k, input logic [3:0] mask,
                           input logic start, input logic [7:0] dout);
      if (k < ev_q.size()) begin
         check($sformatf("%s ev%0d mask", name, k), 32'(ev_q[k].mask), 32'(mask));
         check($sformatf("%s ev%0d start", name, k), 32'(ev_q[k].start), 32'(start));
         check($sformatf("%s ev%0d dout", name, k), 32'(ev_q[k].dout), 32'(dout));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rx;
      logic [7:0]  rxb [4];
      int unsigned exp_n;

      set_vec(0, "hid",    4, 8'h01, 8'h03, 8'h80, 8'h20, 4'b0010, 8'h5c, 8'h22, 8'h22, 8'h22);
      set_vec(1, "sys",    4, 8'h00, 8'ha5, 8'h5a, 8'hff, 4'b0001, 8'h5c, 8'h11, 8'h11, 8'h11);
      set_vec(2, "osd",    3, 8'h02, 8'h42, 8'h00, 8'h00, 4'b0100, 8'h5c, 8'h33, 8'h33, 8'h00);
      set_vec(3, "sdc",    4, 8'h03, 8'hc3, 8'h3c, 8'h81, 4'b1000, 8'h5c, 8'h44, 8'h44, 8'h44);
      set_vec(4, "bad07",  4, 8'h07, 8'h12, 8'h34, 8'h56, 4'b0000, 8'h5c, 8'h00, 8'h00, 8'h00);
      set_vec(5, "bad04",  3, 8'h04, 8'h01, 8'h02, 8'h00, 4'b0000, 8'h5c, 8'h00, 8'h00, 8'h00);

      reset = 1'b1;
      ss    = 1'b1;
      sck   = 1'b0;
      mosi  = 1'b0;
      bus.mcu_sys_din = 8'h11;
      bus.mcu_hid_din = 8'h22;
      bus.mcu_osd_din = 8'h33;
      bus.mcu_sdc_din = 8'h44;
      repeat (4) @(negedge clk);
      check("reset strobes", {28'd0, bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
                              bus.mcu_hid_strobe, bus.mcu_sys_strobe}, 32'd0);
      check("reset start", 32'(bus.mcu_start), 32'd0);
      check("reset dout", 32'(bus.mcu_dout), 32'h00);
      check("reset miso", 32'(miso), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Whole transfers from the table.
      for (int v = 0; v < 6; v++) begin
         ev_q.delete();
         ss = 1'b0;
         for (int unsigned b = 0; b < vecs[v].n; b++) begin
            spi_bits(vecs[v].tx[b], 8, rx);
            rxb[b] = rx;
         end
         ss_end(8);
         exp_n = (vecs[v].mask != 4'b0000) ? vecs[v].n - 1 : 0;
         check({vecs[v].name, " strobe count"}, 32'(ev_q.size()), 32'(exp_n));
         for (int unsigned k = 0; k < exp_n; k++)
            check_ev(vecs[v].name, int'(k), vecs[v].mask, (k == 0), vecs[v].tx[k + 1]);
         for (int unsigned b = 0; b < vecs[v].n; b++)
            check($sformatf("%s miso%0d", vecs[v].name, b), 32'(rxb[b]), 32'(vecs[v].miso[b]));
      end

      // Reply byte follows the target's din as sampled after the previous byte.
      bus.mcu_hid_din = 8'h00;
      ev_q.delete();
      ss = 1'b0;
      spi_bits(8'h01, 8, rxb[0]);
      bus.mcu_hid_din = 8'h01;
      spi_bits(8'h00, 8, rxb[1]);
      spi_bits(8'h00, 8, rxb[2]);
      spi_bits(8'h00, 8, rxb[3]);
      ss_end(8);
      check("din miso0", 32'(rxb[0]), 32'h5c);
      check("din miso1", 32'(rxb[1]), 32'h00);
      check("din miso2", 32'(rxb[2]), 32'h01);
      check("din miso3", 32'(rxb[3]), 32'h01);
      check("din strobe count", 32'(ev_q.size()), 32'd3);
      bus.mcu_hid_din = 8'h22;

      // Partial byte at ss rise is dropped; next transfer decodes from TARGET.
      ev_q.delete();
      ss = 1'b0;
      spi_bits(8'h02, 8, rx);
      spi_bits(8'h55, 8, rx);
      spi_bits(8'ha0, 4, rx);
      ss_end(8);
      check("partial strobe count", 32'(ev_q.size()), 32'd1);
      check_ev("partial", 0, 4'b0100, 1'b1, 8'h55);
      ev_q.delete();
      ss = 1'b0;
      spi_bits(8'h02, 8, rx);
      spi_bits(8'h77, 8, rx);
      ss_end(8);
      check("after partial count", 32'(ev_q.size()), 32'd1);
      check_ev("after partial", 0, 4'b0100, 1'b1, 8'h77);

      // Reset mid-byte in DATA: ignored until ss toggles.
      ev_q.delete();
      ss = 1'b0;
      spi_bits(8'h03, 8, rx);
      spi_bits(8'h10, 8, rx);
      spi_bits(8'h20, 8, rx);
      spi_bits(8'hf0, 4, rx);
      check("pre-reset strobe count", 32'(ev_q.size()), 32'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset strobes", {28'd0, bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
                                 bus.mcu_hid_strobe, bus.mcu_sys_strobe}, 32'd0);
      check("midreset start", 32'(bus.mcu_start), 32'd0);
      check("midreset dout", 32'(bus.mcu_dout), 32'h00);
      check("midreset miso", 32'(miso), 32'd0);
      ev_q.delete();
      spi_bits(8'h0f, 4, rx);
      spi_bits(8'h99, 8, rx);
      check("post-reset ignored", 32'(ev_q.size()), 32'd0);
      check("post-reset miso", 32'(rx), 32'h00);
      ss_end(8);
      ss = 1'b0;
      spi_bits(8'h03, 8, rx);
      spi_bits(8'h11, 8, rx);
      ss_end(8);
      check("resume strobe count", 32'(ev_q.size()), 32'd1);
      check_ev("resume", 0, 4'b1000, 1'b1, 8'h11);

      // Back-to-back transfers with ss high for only 4 clk.
      ev_q.delete();
      ss = 1'b0;
      spi_bits(8'h01, 8, rx);
      spi_bits(8'h40, 8, rx);
      ss_end(4);
      ss = 1'b0;
      spi_bits(8'h03, 8, rx);
      check("b2b miso0", 32'(rx), 32'h5c);
      spi_bits(8'h66, 8, rx);
      ss_end(8);
      check("b2b strobe count", 32'(ev_q.size()), 32'd2);
      check_ev("b2b", 0, 4'b0010, 1'b1, 8'h40);
      check_ev("b2b", 1, 4'b1000, 1'b1, 8'h66);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
